// File: rtl/multicycle_alu.sv
// ---------------------------------------------------------------------------
// multicycle_alu
//   Handshaked ALU with registered outputs. Most opcodes finish one cycle
//   after accept. A left shift (SLL) walks one bit per cycle through a
//   working register. Branch opcodes (BEQ/BLT/BGE) return a-b and put the
//   branch condition on `zero`. Undefined opcodes return 0 with zero=1 and
//   illegal_op=1.
//
//   Build option: define FAST_SHIFT_EN to replace the iterative shifter with
//   a single-cycle barrel shift. The SHIFT state is then never entered.
//
// Parameters
//   WIDTH       datapath width, power of two, 8..64
// Ports
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   in_valid    operand/opcode bundle valid
//   in_ready    block can accept a bundle (IDLE only)
//   Operation   4-bit ALU opcode
//   a, b        operands
//   out_valid   result/zero/illegal_op valid (DONE only)
//   out_ready   consumer takes the result
//   result      registered result
//   zero        registered zero / branch-taken flag
//   illegal_op  registered undefined-opcode flag
// ---------------------------------------------------------------------------
module multicycle_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_BLT  = 4'b1000;
  localparam logic [3:0] OP_BGE  = 4'b1010;
  localparam logic [3:0] OP_ADD4 = 4'b1110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [SH_W-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_work;
  logic [WIDTH-1:0]  r_result;
  logic              r_zero;
  logic              r_ill;
  logic              r_in_ready;
  logic              r_out_valid;

  logic [SH_W-1:0]   w_shamt;
  logic [WIDTH-1:0]  w_diff;
  logic [WIDTH-1:0]  w_res;
  logic              w_zero;
  logic              w_ill;
  logic              w_branch;
  logic              w_iter;
  logic [WIDTH-1:0]  w_work_nxt;

  assign w_shamt    = b[SH_W-1:0];
  assign w_diff     = a - b;
  assign w_work_nxt = {r_work[WIDTH-2:0], 1'b0};

  // Single-cycle result for the bundle currently on the inputs. For an
  // iterative SLL only w_iter matters; the value is produced in SHIFT.
  always_comb begin
    w_res    = '0;
    w_zero   = 1'b0;
    w_ill    = 1'b0;
    w_branch = 1'b0;
    w_iter   = 1'b0;
    case (Operation)
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_ADD:  w_res = a + b;
      OP_SUB:  w_res = w_diff;
      OP_ADD4: w_res = a + WIDTH'(4);
      OP_SLL: begin
`ifdef FAST_SHIFT_EN
        w_res  = a << w_shamt;
`else
        // shamt==0 finishes immediately with result=a
        w_res  = a;
        w_iter = (w_shamt != '0);
`endif
      end
      OP_BEQ: begin
        w_res    = w_diff;
        w_branch = 1'b1;
        w_zero   = (a == b);
      end
      OP_BLT: begin
        w_res    = w_diff;
        w_branch = 1'b1;
        w_zero   = ($signed(a) < $signed(b));
      end
      OP_BGE: begin
        w_res    = w_diff;
        w_branch = 1'b1;
        w_zero   = ($signed(a) >= $signed(b));
      end
      default: begin
        w_res = '0;
        w_ill = 1'b1;
      end
    endcase
    // Illegal opcodes yield result 0, so this also gives them zero=1.
    if (!w_branch) w_zero = (w_res == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ill       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (w_iter) begin
              r_work  <= a;
              r_cnt   <= w_shamt;
              r_state <= SHIFT;
            end else begin
              r_result    <= w_res;
              r_zero      <= w_zero;
              r_ill       <= w_ill;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        SHIFT: begin
          // One bit per cycle; the last step writes straight into result
          // so DONE appears exactly shamt cycles after entering SHIFT.
          r_work <= w_work_nxt;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == SH_W'(1)) begin
            r_result    <= w_work_nxt;
            r_zero      <= (w_work_nxt == '0);
            r_ill       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // Ready rises only after the consume cycle, never in it.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign zero       = r_zero;
  assign illegal_op = r_ill;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  localparam int W = 64;
`ifdef FAST_SHIFT_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   Operation;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal_op;

  int checks = 0;
  int errors = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [3:0] op;
    logic [63:0] xa, xb;
    logic [63:0] er;
    logic       ez, ei;
    int         lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: result/flags straight from the opcode table, latency from
  // the shift amount (one cycle per bit plus one, unless barrel shifting).
  function automatic void model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                                output logic [63:0] r, output logic z, output logic il, output int lat);
    int sh;
    sh  = int'(y[5:0]);
    lat = 1;
    il  = 1'b0;
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b1110: r = x + 64'd4;
      4'b0011: begin
        r = x << sh;
        if (FAST == 0) lat = sh + 1;
      end
      4'b0101, 4'b1000, 4'b1010: r = x - y;
      default: begin r = '0; il = 1'b1; end
    endcase
    z = (r == 0);
    if (op == 4'b0101) z = (x == y);
    if (op == 4'b1000) z = ($signed(x) <  $signed(y));
    if (op == 4'b1010) z = ($signed(x) >= $signed(y));
  endfunction

  task automatic run_op(input string nm, input logic [3:0] op, input logic [63:0] xa, input logic [63:0] xb,
                        input logic [63:0] er, input logic ez, input logic ei, input int el);
    int t;
    int lat;
    t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    Operation = op; a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Inputs are ignored once the bundle is taken
    Operation = 4'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    chk({nm, " latency"}, 64'(lat), 64'(el));
    chk({nm, " result"}, result, er);
    chk({nm, " zero"}, 64'(zero), 64'(ez));
    chk({nm, " illegal"}, 64'(illegal_op), 64'(ei));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " back_idle"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  localparam logic [3:0] DEF_OPS [9] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h3, 4'hE, 4'h5, 4'h8, 4'hA};

  initial begin
    logic [63:0] er;
    logic        ez, ei;
    int          el, cnt;
    logic [3:0]  op;
    logic [63:0] xa, xb;

    vecs[0]  = '{"add",      4'b0010, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 1};
    vecs[1]  = '{"and",      4'b0000, 64'hF0F0, 64'h0FF0, 64'h00F0, 1'b0, 1'b0, 1};
    vecs[2]  = '{"or",       4'b0001, 64'hF000, 64'h000F, 64'hF00F, 1'b0, 1'b0, 1};
    vecs[3]  = '{"sub_zero", 4'b0110, 64'd9, 64'd9, 64'd0, 1'b1, 1'b0, 1};
    vecs[4]  = '{"add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0, 1'b0, 1};
    vecs[5]  = '{"add4",     4'b1110, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 1'b1, 1'b0, 1};
    vecs[6]  = '{"blt",      4'b1000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b0, 1};
    vecs[7]  = '{"bge",      4'b1010, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0, 1};
    vecs[8]  = '{"beq",      4'b0101, 64'd33, 64'd33, 64'd0, 1'b1, 1'b0, 1};
    vecs[9]  = '{"sll4",     4'b0011, 64'd1, 64'd4, 64'd16, 1'b0, 1'b0, FAST ? 1 : 5};
    vecs[10] = '{"sll0",     4'b0011, 64'hABCD, 64'h40, 64'hABCD, 1'b0, 1'b0, 1};
    vecs[11] = '{"sll63",    4'b0011, 64'd3, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0, FAST ? 1 : 64};
    vecs[12] = '{"sll_out",  4'b0011, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 1'b1, 1'b0, FAST ? 1 : 2};
    vecs[13] = '{"illegal",  4'b1111, 64'd9, 64'd9, 64'd0, 1'b1, 1'b1, 1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Operation = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst outs", {result[61:0], zero, illegal_op}, 64'd0);

    // ADD with the consumer always ready: one-cycle result then IDLE
    out_ready = 1'b1;
    Operation = 4'b0010; a = 64'd5; b = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("add1 valid", 64'(out_valid), 64'd1);
    chk("add1 result", result, 64'd12);
    chk("add1 zero", 64'(zero), 64'd0);
    @(posedge clk); #1;
    chk("add1 idle", {62'd0, out_valid, in_ready}, 64'd1);
    out_ready = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].nm, vecs[i].op, vecs[i].xa, vecs[i].xb, vecs[i].er, vecs[i].ez, vecs[i].ei, vecs[i].lat);

    // Stalled consumer: result held, no new accepts
    Operation = 4'b0001; a = 64'h1234; b = 64'h0800; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      Operation = 4'b0010; a = 64'(k + 100); b = 64'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold result", result, 64'h1A34);
      chk("hold hs", {62'd0, out_valid, in_ready}, 64'd2);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("hold released", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("hold no ghost", 64'(out_valid), 64'd0);

    // Reset in cycle 2 of an SLL by 10
    Operation = 4'b0011; a = 64'd1; b = 64'd10; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("rstmid hs", {62'd0, out_valid, in_ready}, 64'd1);
    chk("rstmid result", result, 64'd0);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("rstmid discarded", 64'(cnt), 64'd0);

    // Randomized against the reference model
    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : DEF_OPS[$urandom_range(0, 8)];
      xa = {$urandom, $urandom};
      xb = ($urandom_range(0, 3) == 0) ? xa : {$urandom, $urandom};
      if (op == 4'b0011) xb = {$urandom, 26'd0, 6'($urandom_range(0, 20))};
      model(op, xa, xb, er, ez, ei, el);
      run_op($sformatf("rnd%0d op%0h", n, op), op, xa, xb, er, ez, ei, el);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64: datapath width; a power of two, 8 to 64.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have input in_valid, 1 bit: the operand/opcode bundle is valid.
REQ-005 The block SHALL have output in_ready, 1 bit: the block accepts a bundle this cycle.
REQ-006 The block SHALL have input Operation, 4 bits: ALU opcode from the ALU control stage.
REQ-007 The block SHALL have inputs a and b, WIDTH bits each: operands.
REQ-008 The block SHALL have output out_valid, 1 bit: result and zero are valid.
REQ-009 The block SHALL have input out_ready, 1 bit: the consumer takes the result this cycle.
REQ-010 The block SHALL have output result, WIDTH bits: registered result.
REQ-011 The block SHALL have output zero, 1 bit: registered branch/zero flag.
REQ-012 The block SHALL have output illegal_op, 1 bit: registered flag, set when the captured opcode is undefined.

Function
REQ-013 The block SHALL implement states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, when in_valid is 1, the block SHALL capture Operation, a and b (accept handshake); otherwise it SHALL hold.
REQ-015 For every opcode other than 0011, the block SHALL move IDLE->DONE on accept, so out_valid rises 1 cycle after accept.
REQ-016 The block SHALL compute results as: 0000 AND; 0001 OR; 0010 a+b; 0110 a-b; 0011 a<<b[log2(WIDTH)-1:0]; 1110 a+4; all arithmetic modulo 2^WIDTH, carries discarded.
REQ-017 For opcode 0101 (BEQ), result SHALL be a-b and zero SHALL be (a==b).
REQ-018 For opcode 1000 (BLT), result SHALL be a-b and zero SHALL be (signed a < signed b).
REQ-019 For opcode 1010 (BGE), result SHALL be a-b and zero SHALL be (signed a >= signed b).
REQ-020 For all non-branch opcodes, zero SHALL be (result==0).
REQ-021 For any undefined opcode, the block SHALL set result to 0, zero to 1 and illegal_op to 1; for defined opcodes, illegal_op SHALL be 0.
REQ-022 For opcode 0011 with shamt=0, the block SHALL go IDLE->DONE with result=a (latency 1).
REQ-023 For opcode 0011 with shamt=N>0, the block SHALL go IDLE->SHIFT, shift the working register left by 1 bit per cycle for N cycles, then go to DONE (out_valid N+1 cycles after accept).
REQ-024 In DONE, result, zero and illegal_op SHALL stay stable until out_ready is 1; on out_valid&&out_ready, the block SHALL return to IDLE the next cycle.
REQ-025 The block SHALL take no new bundle in the cycle the result is consumed (in_ready asserts the following cycle), giving a back-to-back throughput of 1 operation per 2 cycles minimum.
REQ-026 In SHIFT and DONE, in_valid and input changes SHALL be ignored.

Reset
REQ-027 When reset is 1 at a clock edge, the block SHALL enter IDLE and set result=0, zero=0, illegal_op=0 and the shift counter to 0, which gives in_ready=1 and out_valid=0.
REQ-028 Reset SHALL take priority over every other event, including mid-SHIFT and during DONE while out_ready=1; any in-flight operation SHALL be discarded without producing an output.

Configuration
REQ-029 When macro FAST_SHIFT_EN is defined, opcode 0011 SHALL use a single-cycle barrel shift, go IDLE->DONE with latency 1, and the SHIFT state SHALL never be entered.
REQ-030 When FAST_SHIFT_EN is undefined, opcode 0011 SHALL use the iterative shifter of REQ-023.

Verification
REQ-031 The bench SHALL check: reset, then Operation=0010, a=5, b=7, out_ready=1 -> result=12 and zero=0 one cycle after accept, then IDLE.
REQ-032 The bench SHALL check: Operation=1000, a=-3 (all-ones form), b=2 -> zero=1 and result=-5; and Operation=1010 with the same operands -> zero=0.
REQ-033 The bench SHALL check: Operation=0011, a=1, b=4 -> out_valid 5 cycles after accept with result=16 (macro undefined), or 1 cycle after accept with result=16 (macro defined).
REQ-034 The bench SHALL check: result ready with out_ready=0 for 3 cycles -> result held and in_ready=0, while in_valid pulses are ignored.
REQ-035 The bench SHALL check: reset asserted during cycle 2 of an SLL by 10 -> next cycle IDLE, out_valid=0, result=0.
REQ-036 The bench SHALL check: Operation=1111, a=9, b=9 -> result=0, zero=1 and illegal_op=1.
